arf_sequencer: RTL and testbench

- Micro-sequencer that drives the control inputs of the address register file (PC, AR, SP) plus the memory read/write strobes.
- Accepts one high-level address command at a time over a valid/ready handshake.
- Expands each command into 1–3 fixed micro-steps: fetch, jump, call/return, push/pop, AR load, SP init.
- Sits between the instruction decoder and the address register file / memory.

---
 rtl/arf_sequencer_if.sv | 34 +++
 rtl/arf_sequencer.sv | 148 ++++++++++++++
 tb/tb_arf_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arf_sequencer_if.sv
// Command handshake plus ARF/memory control bundle
// for arf_sequencer.
interface arf_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              Cmd_Valid;
  logic              Cmd_Ready;
  logic [2:0]        Cmd_Op;
  logic [DATA_W-1:0] Cmd_Data;
  logic [DATA_W-1:0] Mem_Data;
  logic [DATA_W-1:0] ArfI;
  logic [2:0]        FunSel;
  logic [2:0]        RegSel;
  logic [1:0]        OutCSel;
  logic [1:0]        OutDSel;
  logic              Mem_Rd;
  logic              Mem_Wr;
  logic              Done;
  logic              Err;

  modport master (
    output Cmd_Valid, Cmd_Op, Cmd_Data, Mem_Data,
    input  Cmd_Ready, ArfI, FunSel, RegSel,
    input  OutCSel, OutDSel, Mem_Rd, Mem_Wr,
    input  Done, Err
  );

  modport slave (
    input  Cmd_Valid, Cmd_Op, Cmd_Data, Mem_Data,
    output Cmd_Ready, ArfI, FunSel, RegSel,
    output OutCSel, OutDSel, Mem_Rd, Mem_Wr,
    output Done, Err
  );
endinterface

// File: rtl/arf_sequencer.sv
// Address-register-file micro-sequencer (PC/AR/SP + mem strobes).
// Define ARF_SEQ_STACK_CHECK_EN to add stack depth checking.
module arf_sequencer #(
  parameter int              DATA_W      = 16,
  parameter logic [DATA_W-1:0] STACK_TOP = 16'h00FF,
  parameter int              STACK_DEPTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  arf_sequencer_if.slave bus
);

  typedef enum logic [4:0] {
    IDLE, N0, F_ADDR, F_INC, J_LD,
    C_DEC, C_WR, C_LD,
    R_RD, R_LD, R_INC,
    P_DEC, P_WR,
    O_RD, O_LD, O_INC,
    S_LD, ERR
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] data_q;
  logic              accept;
  logic              full;
  logic              empty;

  assign bus.Cmd_Ready = (state_q == IDLE) & rst_n;
  assign accept = bus.Cmd_Valid & bus.Cmd_Ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) data_q <= bus.Cmd_Data;
    end
  end

`ifdef ARF_SEQ_STACK_CHECK_EN
  localparam int DEP_W = $clog2(STACK_DEPTH + 1);

  logic [DEP_W-1:0] depth_q;

  assign full  = (depth_q == DEP_W'(STACK_DEPTH));
  assign empty = (depth_q == '0);
  assign bus.Err = (state_q == ERR);

  // Depth follows the Done step of each stack command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
    end else begin
      case (state_q)
        C_LD, P_WR:   depth_q <= depth_q + 1'b1;
        R_INC, O_INC: depth_q <= depth_q - 1'b1;
        S_LD:         depth_q <= '0;
        default:      ;
      endcase
    end
  end
`else
  assign full    = 1'b0;
  assign empty   = 1'b0;
  assign bus.Err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.Cmd_Op)
            3'b001:  state_d = F_ADDR;
            3'b010:  state_d = J_LD;
            3'b011:  state_d = full  ? ERR : C_DEC;
            3'b100:  state_d = empty ? ERR : R_RD;
            3'b101:  state_d = full  ? ERR : P_DEC;
            3'b110:  state_d = empty ? ERR : O_RD;
            3'b111:  state_d = S_LD;
            default: state_d = N0;
          endcase
        end
      end
      F_ADDR:  state_d = F_INC;
      C_DEC:   state_d = C_WR;
      C_WR:    state_d = C_LD;
      R_RD:    state_d = R_LD;
      R_LD:    state_d = R_INC;
      P_DEC:   state_d = P_WR;
      O_RD:    state_d = O_LD;
      O_LD:    state_d = O_INC;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.RegSel  = 3'b111;
    bus.FunSel  = 3'b000;
    bus.OutCSel = 2'b00;
    bus.OutDSel = 2'b00;
    bus.Mem_Rd  = 1'b0;
    bus.Mem_Wr  = 1'b0;
    bus.Done    = 1'b0;
    bus.ArfI    = data_q;
    case (state_q)
      N0: bus.Done = 1'b1;
      F_ADDR: bus.Mem_Rd = 1'b1;
      F_INC, J_LD, C_LD: begin
        bus.RegSel = 3'b011;
        bus.FunSel = (state_q == F_INC) ? 3'b001 : 3'b010;
        bus.Done   = 1'b1;
      end
      C_DEC, P_DEC: bus.RegSel = 3'b110;
      C_WR, P_WR: begin
        bus.OutDSel = 2'b11;
        bus.OutCSel = (state_q == P_WR) ? 2'b10 : 2'b00;
        bus.Mem_Wr  = 1'b1;
        bus.Done    = (state_q == P_WR);
      end
      R_RD, O_RD: begin
        bus.OutDSel = 2'b11;
        bus.Mem_Rd  = 1'b1;
      end
      R_LD, O_LD: begin
        bus.RegSel = (state_q == R_LD) ? 3'b011 : 3'b101;
        bus.FunSel = 3'b010;
        bus.ArfI   = bus.Mem_Data;
      end
      R_INC, O_INC: begin
        bus.RegSel = 3'b110;
        bus.FunSel = 3'b001;
        bus.Done   = 1'b1;
      end
      S_LD: begin
        bus.RegSel = 3'b110;
        bus.FunSel = 3'b010;
        bus.ArfI   = STACK_TOP;
        bus.Done   = 1'b1;
      end
      ERR: bus.Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arf_sequencer.sv
// Scoreboard bench for arf_sequencer: ARF/memory plant driven by the
// DUT, high-level command model feeding an expectation queue.
`timescale 1ns/1ps
module tb_arf_sequencer;
  localparam logic [2:0] NOP = 3'd0, FETCH = 3'd1, JUMP = 3'd2;
  localparam logic [2:0] CALL = 3'd3, RET = 3'd4, PUSH = 3'd5;
  localparam logic [2:0] POP = 3'd6, SPINIT = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arf_sequencer_if #(.DATA_W(16)) bus();

  arf_sequencer #(
    .DATA_W(16), .STACK_TOP(16'h00FF), .STACK_DEPTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- plant: ARF registers and memory ----------------
  logic [15:0] pc = 16'h0, ar = 16'h0, sp = 16'h0;
  logic [15:0] mem_data = 16'h0;
  logic [15:0] last_rd = 16'h0, last_wa = 16'h0, last_wd = 16'h0;
  logic [15:0] mem [0:65535] = '{default: 16'h0};
  int nrd = 0, nwr = 0, cyc = 0;
  logic bd_en = 1'b0;
  logic [15:0] bd_pc = 16'h0, bd_ar = 16'h0, bd_sp = 16'h0;

  function automatic logic [15:0] arf_f(input logic [15:0] v,
                                         input logic [2:0] f,
                                         input logic [15:0] i);
    case (f)
      3'b000:  return v - 16'd1;
      3'b001:  return v + 16'd1;
      3'b010:  return i;
      default: return v;
    endcase
  endfunction

  function automatic logic [15:0] sel(input logic [1:0] c);
    case (c)
      2'b00:   return pc;
      2'b10:   return ar;
      2'b11:   return sp;
      default: return 16'hDEAD;
    endcase
  endfunction

  assign bus.Mem_Data = mem_data;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bd_en) begin
      pc <= bd_pc; ar <= bd_ar; sp <= bd_sp;
    end else begin
      if (!bus.RegSel[2]) pc <= arf_f(pc, bus.FunSel, bus.ArfI);
      if (!bus.RegSel[1]) ar <= arf_f(ar, bus.FunSel, bus.ArfI);
      if (!bus.RegSel[0]) sp <= arf_f(sp, bus.FunSel, bus.ArfI);
    end
    if (bus.Mem_Wr) begin
      mem[sel(bus.OutDSel)] <= sel(bus.OutCSel);
      last_wa <= sel(bus.OutDSel);
      last_wd <= sel(bus.OutCSel);
      nwr <= nwr + 1;
    end
    if (bus.Mem_Rd) begin
      mem_data <= mem[sel(bus.OutDSel)];
      last_rd <= sel(bus.OutDSel);
      nrd <= nrd + 1;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] pc, ar, sp, rd_a, wr_a, wr_d;
    int lat, acc, nrd, nwr;
    bit err;
  } exp_t;

  exp_t exp_q [$];
  logic [15:0] m_pc, m_ar, m_sp;
  logic [15:0] m_mem [0:65535] = '{default: 16'h0};
  int m_depth = 0;

  task automatic model(input logic [2:0] op, input logic [15:0] d,
                       output exp_t e);
    bit fault = 1'b0;
    e.rd_a = '0; e.wr_a = '0; e.wr_d = '0;
    e.nrd = 0; e.nwr = 0; e.lat = 1; e.acc = 0;
`ifdef ARF_SEQ_STACK_CHECK_EN
    if ((op == CALL || op == PUSH) && m_depth == 32) fault = 1'b1;
    if ((op == RET || op == POP) && m_depth == 0) fault = 1'b1;
`endif
    e.err = fault;
    if (!fault) begin
      case (op)
        FETCH: begin
          e.lat = 2; e.nrd = 1; e.rd_a = m_pc;
          m_pc = m_pc + 16'd1;
        end
        JUMP: m_pc = d;
        CALL: begin
          e.lat = 3; m_sp = m_sp - 16'd1;
          m_mem[m_sp] = m_pc;
          e.nwr = 1; e.wr_a = m_sp; e.wr_d = m_pc;
          m_pc = d; m_depth++;
        end
        RET: begin
          e.lat = 3; e.nrd = 1; e.rd_a = m_sp;
          m_pc = m_mem[m_sp]; m_sp = m_sp + 16'd1; m_depth--;
        end
        PUSH: begin
          e.lat = 2; m_sp = m_sp - 16'd1;
          m_mem[m_sp] = m_ar;
          e.nwr = 1; e.wr_a = m_sp; e.wr_d = m_ar; m_depth++;
        end
        POP: begin
          e.lat = 3; e.nrd = 1; e.rd_a = m_sp;
          m_ar = m_mem[m_sp]; m_sp = m_sp + 16'd1; m_depth--;
        end
        SPINIT: begin m_sp = 16'h00FF; m_depth = 0; end
        default: ;
      endcase
    end
    e.pc = m_pc; e.ar = m_ar; e.sp = m_sp;
  endtask

  // ---------------- monitor ----------------
  int prev_nrd = 0, prev_nwr = 0;

  initial begin : monitor
    exp_t e;
    int d_cyc;
    logic d_err;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (bus.Err && !bus.Done) chk("err_without_done", 32'd1, 32'd0);
      if (bus.Done) begin
        d_cyc = cyc;
        d_err = bus.Err;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("err", 32'(d_err), 32'(e.err));
          chk("latency", d_cyc - e.acc + 1, e.lat);
          chk("pc", pc, e.pc);
          chk("ar", ar, e.ar);
          chk("sp", sp, e.sp);
          chk("reads", nrd - prev_nrd, e.nrd);
          chk("writes", nwr - prev_nwr, e.nwr);
          if (e.nrd > 0) chk("rd_addr", last_rd, e.rd_a);
          if (e.nwr > 0) begin
            chk("wr_addr", last_wa, e.wr_a);
            chk("wr_data", last_wd, e.wr_d);
          end
        end
        prev_nrd = nrd;
        prev_nwr = nwr;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [2:0] op, input logic [15:0] d,
                       output int acc);
    exp_t e;
    int n = 0;
    acc = -1;
    @(negedge clk);
    bus.Cmd_Valid = 1'b1;
    bus.Cmd_Op = op;
    bus.Cmd_Data = d;
    while (!bus.Cmd_Ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.Cmd_Ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    model(op, d, e);
    e.acc = acc;
    exp_q.push_back(e);
  endtask

  task automatic idle_check(input int n);
    int k = 0;
    @(negedge clk);
    bus.Cmd_Valid = 1'b0;
    while (!bus.Cmd_Ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'(bus.Cmd_Ready), 32'd1);
      chk("idle_regsel", 32'(bus.RegSel), 32'd7);
      chk("idle_strobes", {bus.Mem_Rd, bus.Mem_Wr}, 32'd0);
    end
  endtask

  task automatic backdoor(input logic [15:0] p, input logic [15:0] a,
                          input logic [15:0] s);
    @(negedge clk);
    bd_pc = p; bd_ar = a; bd_sp = s; bd_en = 1'b1;
    @(posedge clk);
    #1;
    bd_en = 1'b0;
    m_pc = p; m_ar = a; m_sp = s;
  endtask

  initial begin : stim
    int a0, a1;
    logic [2:0] op;
    bus.Cmd_Valid = 1'b0;
    bus.Cmd_Op = NOP;
    bus.Cmd_Data = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.Cmd_Ready), 32'd0);
    chk("rst_regsel", 32'(bus.RegSel), 32'd7);
    chk("rst_funsel", 32'(bus.FunSel), 32'd0);
    chk("rst_outsel", {bus.OutCSel, bus.OutDSel}, 32'd0);
    chk("rst_arfi", 32'(bus.ArfI), 32'd0);
    chk("rst_flags", {bus.Mem_Rd, bus.Mem_Wr, bus.Done, bus.Err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(bus.Cmd_Ready), 32'd1);

    // abort a CALL during its write step
    bus.Cmd_Valid = 1'b1;
    bus.Cmd_Op = CALL;
    bus.Cmd_Data = 16'h0040;
    @(posedge clk);
    #1;
    bus.Cmd_Valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("cwr_strobe", 32'(bus.Mem_Wr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_regsel", 32'(bus.RegSel), 32'd7);
    chk("abort_memwr", 32'(bus.Mem_Wr), 32'd0);
    chk("abort_ready", 32'(bus.Cmd_Ready), 32'd0);
    chk("abort_arfi", 32'(bus.ArfI), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_release", 32'(bus.Cmd_Ready), 32'd1);
    m_depth = 0;

    backdoor(16'h0010, 16'h1234, 16'h0000);
    issue(SPINIT, 16'h0, a0);
    issue(PUSH, 16'h0, a0);
    issue(POP, 16'h0, a0);
    issue(CALL, 16'h0040, a0);
    issue(RET, 16'h0, a0);
    idle_check(3);

    backdoor(16'h0005, 16'h1234, 16'h00FF);
    issue(FETCH, 16'h0, a0);
    for (int i = 0; i < 3; i++) begin
      issue(FETCH, 16'h0, a1);
      chk("fetch_spacing", a1 - a0, 32'd3);
      a0 = a1;
    end
    idle_check(5);

`ifdef ARF_SEQ_STACK_CHECK_EN
    issue(SPINIT, 16'h0, a0);
    issue(POP, 16'h0, a0);
    for (int i = 0; i < 33; i++) issue(PUSH, 16'(i), a0);
    issue(SPINIT, 16'h0, a0);
`endif

    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      issue(op, 16'($urandom), a0);
      if ($urandom_range(0, 9) == 0) idle_check(2);
    end
    idle_check(3);

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) chk("drain", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
